// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment bus back into BCD digits. Each strobed
// pattern must be stable for STABLE_CYCLES samples before its slot commits.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   invalid,
  output logic                    overrun
);
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNTING, LOCKED} run_state_t;

  run_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_DIGITS+6:0]   hist_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d, digits_q;
  logic [NUM_DIGITS-1:0]   stage_inv_q, stage_inv_d, invalid_q;
  logic                    out_valid_q, overrun_q;
  logic                    onehot, same, commit, frame_done;
  logic [SLOT_W-1:0]       slot;
  logic [4:0]              dec;

  // Returns {invalid, value}; anything outside the ten digit glyphs reads as F.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7C:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h67:   return 5'h09;
      default: return 5'h1F;
    endcase
  endfunction

  always_comb begin
    onehot = $onehot(digit_en);
    same   = ({digit_en, segments} == hist_q);
    slot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit_en[i]) slot = SLOT_W'(i);
    dec        = decode(segments);
    commit     = onehot && same && (state_q == COUNTING) && (cnt_q == LAST_CNT);
    mask_d     = commit ? (mask_q | digit_en) : mask_q;
    frame_done = commit && (&mask_d);
    stage_val_d = stage_val_q;
    stage_inv_d = stage_inv_q;
    if (commit) begin
      stage_val_d[4*slot +: 4] = dec[3:0];
      stage_inv_d[slot]        = dec[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hist_q      <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      digits_q    <= '0;
      invalid_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      hist_q <= {digit_en, segments};
      if (!onehot) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (!same) begin
        state_q <= COUNTING;
        cnt_q   <= CNT_W'(1);
      end else if (state_q == COUNTING) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (commit) state_q <= LOCKED;
      end
      mask_q <= frame_done ? '0 : mask_d;
      // A completed frame is only loaded if the held one is gone or leaving now.
      if (frame_done && (!out_valid_q || out_ready)) begin
        digits_q    <= stage_val_d;
        invalid_q   <= stage_inv_d;
        out_valid_q <= 1'b1;
      end else if (frame_done) begin
        overrun_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Staging contents are only read once every mask bit has been rewritten.
  always_ff @(posedge clk) begin
    stage_val_q <= stage_val_d;
    stage_inv_q <= stage_inv_d;
  end

  assign out_valid = out_valid_q;
  assign digits    = digits_q;
  assign invalid   = invalid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed vector table plus randomized runs against a
// run-length based reference model of the reader.
module tb_seg7_reader;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segments;
  logic [1:0] digit_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] digits;
  logic [1:0] invalid;
  logic       overrun;

  seg7_reader #(.STABLE_CYCLES(S), .NUM_DIGITS(2)) dut (
    .clk(clk), .reset(reset), .segments(segments), .digit_en(digit_en),
    .out_valid(out_valid), .out_ready(out_ready), .digits(digits),
    .invalid(invalid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [6:0] legal [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  // Reference model state
  int         run_len = 0;
  logic [8:0] prev = '0;
  logic [3:0] m_sval [2] = '{4'h0, 4'h0};
  logic       m_sinv [2] = '{1'b0, 1'b0};
  bit         m_mask [2] = '{1'b0, 1'b0};
  logic       m_valid = 1'b0;
  logic [7:0] m_digits = '0;
  logic [1:0] m_inv = '0;
  logic       m_ovr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] en, input logic [6:0] sg,
                            input logic rdy);
    int  idx;
    bit  done;
    logic [3:0] v;
    logic       bad;
    if (r) begin
      run_len = 0; prev = '0; m_mask[0] = 0; m_mask[1] = 0;
      m_valid = 0; m_digits = '0; m_inv = '0; m_ovr = 0;
      return;
    end
    if (en == 2'b01 || en == 2'b10) run_len = ({en, sg} == prev) ? run_len + 1 : 1;
    else run_len = 0;
    prev = {en, sg};
    done = 0;
    if (run_len == S) begin
      idx = (en == 2'b10) ? 1 : 0;
      v = 4'hF; bad = 1'b1;
      for (int k = 0; k < 10; k++)
        if (legal[k] == sg) begin v = 4'(k); bad = 1'b0; end
      m_sval[idx] = v; m_sinv[idx] = bad; m_mask[idx] = 1;
      if (m_mask[0] && m_mask[1]) begin
        done = 1; m_mask[0] = 0; m_mask[1] = 0;
        if (!m_valid || rdy) begin
          m_valid = 1; m_digits = {m_sval[1], m_sval[0]}; m_inv = {m_sinv[1], m_sinv[0]};
        end else m_ovr = 1;
      end
    end
    if (!done && m_valid && rdy) m_valid = 0;
  endtask

  task automatic apply(input logic r, input logic [1:0] en, input logic [6:0] sg,
                       input logic rdy);
    reset = r; digit_en = en; segments = sg; out_ready = rdy;
    @(posedge clk);
    model_edge(r, en, sg, rdy);
    @(negedge clk);
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_digits", 32'(digits), 32'(m_digits));
    check("model_invalid", 32'(invalid), 32'(m_inv));
    check("model_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [6:0] seg;
    logic       rdy;
    int         reps;
    bit         chk;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ei;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [1:0] en, input logic [6:0] seg,
                              input logic rdy, input int reps, input bit chk,
                              input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                              input logic eo);
    vec_t v;
    v.rst = rst; v.en = en; v.seg = seg; v.rdy = rdy; v.reps = reps; v.chk = chk;
    v.ev = ev; v.ed = ed; v.ei = ei; v.eo = eo;
    vecs.push_back(v);
  endfunction

  initial begin
    // reset
    add(1, 2'b11, 7'h7F, 1, 2, 1, 0, 8'h00, 2'b00, 0);
    // basic frame 92
    add(0, 2'b01, 7'h5B, 0, 4, 1, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h67, 0, 3, 1, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h67, 0, 1, 1, 1, 8'h92, 2'b00, 0);
    add(0, 2'b00, 7'h00, 1, 1, 1, 0, 8'h92, 2'b00, 0);
    // glitch filter
    add(0, 2'b01, 7'h3F, 0, 3, 1, 0, 8'h92, 2'b00, 0);
    add(0, 2'b01, 7'h06, 0, 1, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b01, 7'h3F, 0, 4, 1, 0, 8'h92, 2'b00, 0);
    add(0, 2'b10, 7'h06, 0, 3, 1, 0, 8'h92, 2'b00, 0);
    add(0, 2'b10, 7'h06, 0, 1, 1, 1, 8'h10, 2'b00, 0);
    add(0, 2'b00, 7'h00, 1, 1, 1, 0, 8'h10, 2'b00, 0);
    // invalid pattern
    add(0, 2'b01, 7'h01, 0, 4, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h06, 0, 4, 1, 1, 8'h1F, 2'b01, 0);
    add(0, 2'b00, 7'h00, 1, 1, 1, 0, 8'h1F, 2'b01, 0);
    // overrun: A held, B dropped, then one accept pulse
    add(0, 2'b01, 7'h5B, 0, 4, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h67, 0, 4, 1, 1, 8'h92, 2'b00, 0);
    add(0, 2'b01, 7'h3F, 0, 4, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h06, 0, 4, 1, 1, 8'h92, 2'b00, 1);
    add(0, 2'b00, 7'h00, 1, 1, 1, 0, 8'h92, 2'b00, 1);
    add(0, 2'b00, 7'h00, 0, 1, 1, 0, 8'h92, 2'b00, 1);
    // accept and load on the same edge
    add(0, 2'b01, 7'h06, 0, 4, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h3F, 0, 4, 1, 1, 8'h01, 2'b00, 1);
    add(0, 2'b01, 7'h4F, 0, 4, 0, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h66, 0, 3, 1, 1, 8'h01, 2'b00, 1);
    add(0, 2'b10, 7'h66, 1, 1, 1, 1, 8'h43, 2'b00, 1);
    add(0, 2'b00, 7'h00, 1, 1, 1, 0, 8'h43, 2'b00, 1);
    // illegal strobe, then reset in the middle of a count
    add(0, 2'b11, 7'h3F, 0, 10, 1, 0, 8'h43, 2'b00, 1);
    add(0, 2'b01, 7'h3F, 0, 3, 1, 0, 8'h43, 2'b00, 1);
    add(1, 2'b01, 7'h3F, 0, 1, 1, 0, 8'h00, 2'b00, 0);
    add(0, 2'b01, 7'h3F, 0, 3, 1, 0, 8'h00, 2'b00, 0);
    add(0, 2'b10, 7'h06, 0, 4, 1, 0, 8'h00, 2'b00, 0);
    add(0, 2'b01, 7'h3F, 0, 4, 1, 1, 8'h10, 2'b00, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++)
        apply(vecs[i].rst, vecs[i].en, vecs[i].seg, vecs[i].rdy);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
        check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].ed));
        check($sformatf("vec%0d_invalid", i), 32'(invalid), 32'(vecs[i].ei));
        check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].eo));
      end
    end

    // randomized runs
    for (int r = 0; r < 2; r++)
      apply(1'b1, 2'($urandom), 7'($urandom), 1'($urandom));
    for (int n = 0; n < 3000; ) begin
      int         hold, sel;
      logic [1:0] en;
      logic [6:0] sg;
      hold = $urandom_range(1, 6);
      sel  = $urandom_range(0, 9);
      en   = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11;
      sg   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal[$urandom_range(0, 9)];
      for (int h = 0; h < hold; h++) begin
        apply(($urandom_range(0, 299) == 0), en, sg, ($urandom_range(0, 3) == 0));
        n++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
